// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit: reset vector,
// NOP encoding, FSM state encodings and the buffered fetch entry layout.
package inst_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0000;

   localparam logic [1:0] ST_REQ     = 2'd0;
   localparam logic [1:0] ST_WAIT    = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   typedef struct packed {
      logic        adel;
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

   function automatic logic pc_misaligned(input logic [1:0] pc_lo);
      return (pc_lo != 2'b00);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched instructions; flush empties it and
// overrides any same-cycle push/pop, push into a full FIFO is legal with a pop.
module fetch_fifo #(
   parameter int WIDTH = 65,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             do_push_s, do_pop_s;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == {(PW+1){1'b0}});
   assign head_data = mem_q[rd_ptr_q];

   // next-state pointers, occupancy and storage
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      do_pop_s  = pop && !empty;
      do_push_s = push && (!full || do_pop_s);
      if (flush) begin
         wr_ptr_d = {PW{1'b0}};
         rd_ptr_d = {PW{1'b0}};
         count_d  = {(PW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1'b1);
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end
         count_d = count_q + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
      end
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         count_q  <= {(PW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding memory request, redirect handling and
// a decoupling buffer to decode. Optional macro IF_BYPASS_EN: same-cycle bypass.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic        id_adel
);

   logic [1:0]   state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic         inst_req_s;
   logic         fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s;
   fetch_entry_t push_entry_s, head_s;
   logic [31:0]  req_pc_s;

   // pc_q has already advanced past the outstanding request
   assign req_pc_s   = pc_q - 32'd4;
   assign fifo_pop_s = !fifo_empty_s && id_ready;
   assign inst_req   = inst_req_s;
   assign inst_addr  = pc_q;

   // fetch FSM: request issue, response capture, redirect and misaligned PC
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_req_s   = 1'b0;
      fifo_push_s  = 1'b0;
      push_entry_s = '{adel: 1'b0, pc: req_pc_s, inst: inst_rdata};
      case (state_q)
         ST_REQ: begin
            inst_req_s = resetn && !pc_misaligned(pc_q[1:0]) && !fifo_full_s;
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = (inst_req_s && inst_addr_ok) ? ST_DISCARD : ST_REQ;
            end else if (inst_req_s && inst_addr_ok) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_WAIT;
            end else if (pc_misaligned(pc_q[1:0]) && (!fifo_full_s || fifo_pop_s)) begin
               fifo_push_s  = 1'b1;
               push_entry_s = '{adel: 1'b1, pc: pc_q, inst: NOP_INST};
               state_d      = ST_HALT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = inst_data_ok ? ST_REQ : ST_DISCARD;
            end else if (inst_data_ok) begin
`ifdef IF_BYPASS_EN
               fifo_push_s = !(fifo_empty_s && id_ready);
`else
               fifo_push_s = 1'b1;
`endif
               state_d = ST_REQ;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DISCARD: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end else begin
               pc_d = pc_q;
            end
            state_d = inst_data_ok ? ST_REQ : ST_DISCARD;
         end
         ST_HALT: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // FSM and fetch PC registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ST_REQ;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   fetch_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (redirect),
      .push      (fifo_push_s),
      .push_data (push_entry_s),
      .pop       (fifo_pop_s),
      .head_data (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

`ifdef IF_BYPASS_EN
   logic bypass_s;

   assign bypass_s = resetn && fifo_empty_s && (state_q == ST_WAIT) && inst_data_ok && !redirect;
   assign id_valid = !fifo_empty_s || bypass_s;
   assign id_inst  = bypass_s ? inst_rdata : head_s.inst;
   assign id_pc    = bypass_s ? req_pc_s : head_s.pc;
   assign id_adel  = bypass_s ? 1'b0 : head_s.adel;
`else
   assign id_valid = !fifo_empty_s;
   assign id_inst  = head_s.inst;
   assign id_pc    = head_s.pc;
   assign id_adel  = head_s.adel;
`endif

endmodule
